// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage, the instruction memory and decode.
//
// Handshake: a {instr_out, instr_pc} transfer happens on every rising clk
// edge where instr_valid & instr_ready are both 1. Once instr_valid is high,
// it stays high and the payload stays stable until that transfer happens.
// A redirect is the only exception: it discards the entry.
// instr_valid never depends combinationally on instr_ready.
// The memory side has no handshake. imem_rd_en=1 is one read request, and
// its data is expected on imem_rdata in the following cycle.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH  = 7,
    parameter int INSTR_WIDTH = 32
);
    logic                   fetch_en;
    logic                   imem_rd_en;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_addr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]  instr_pc;

    // Fetch-stage side.
    modport master (
        input  fetch_en,
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_addr,
        output instr_valid,
        input  instr_ready,
        output instr_out,
        output instr_pc
    );

    // Environment side: memory, branch unit and decode.
    modport slave (
        output fetch_en,
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_addr,
        input  instr_valid,
        output instr_ready,
        input  instr_out,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// It issues one word read per cycle to a synchronous-read memory and captures
// each response one cycle later. Responses go into a 2-entry FIFO that feeds
// decode. Issue is gated on occupancy (entries + response in flight - pop).
// Because of that gate, every response always has a free slot.
// A redirect flushes the FIFO and the response in flight, then restarts at
// the target address.
module instr_fetch #(
    parameter int ADDR_NUM    = 128,
    parameter int ADDR_WIDTH  = $clog2(ADDR_NUM),
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus,
    output logic           dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ADDR_WIDTH'(ADDR_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_W = ADDR_WIDTH'(RESET_PC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Program counter and the response in flight.
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  req_pc;
    logic                   pending;

    // 2-entry FIFO storage.
    logic [INSTR_WIDTH-1:0] fifo_instr [2];
    logic [ADDR_WIDTH-1:0]  fifo_pc    [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occ;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic [ADDR_WIDTH-1:0]  pc_nxt;

    // Word-address increment.
    // The memory depth need not be a power of two, so wrap explicitly.
    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_PC) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    // Head of the FIFO is what decode sees; valid whenever anything is buffered.
    always_comb begin
        bus.instr_valid = (count != 2'd0);
        bus.instr_out   = fifo_instr[rd_ptr];
        bus.instr_pc    = fifo_pc[rd_ptr];
    end

    // Issue decision, request address and next pc.
    always_comb begin
        pop  = bus.instr_valid & bus.instr_ready;
        occ  = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
        push = pending & ~bus.redirect_valid;
        // rst_n gates the strobe so that no request leaves while reset is held.
        // This applies even though fetch_en may already be high.
        if (!rst_n) begin
            issue = 1'b0;
        end else if (bus.redirect_valid) begin
            // A redirect flushes everything, so the occupancy gate is irrelevant.
            issue = bus.fetch_en;
        end else begin
            issue = bus.fetch_en & (occ < 3'd2);
        end
        issue_addr = bus.redirect_valid ? bus.redirect_addr : pc;
        if (bus.redirect_valid) begin
            pc_nxt = bus.fetch_en ? pc_inc(bus.redirect_addr) : bus.redirect_addr;
        end else begin
            pc_nxt = issue ? pc_inc(pc) : pc;
        end
        bus.imem_rd_en = issue;
        bus.imem_addr  = issue_addr;
    end

    // Advance the pc and remember which address the in-flight response belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC_W;
            pending <= 1'b0;
            req_pc  <= '0;
        end else begin
            pc      <= pc_nxt;
            pending <= issue;
            if (issue) begin
                req_pc <= issue_addr;
            end
        end
    end

    // FIFO write, read and flush.
    // A redirect keeps a same-cycle pop but drops every other entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (bus.redirect_valid) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= bus.imem_rdata;
                fifo_pc[wr_ptr]    <= req_pc;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Activity state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE until fetching is enabled.
    // Return to IDLE only once disabled and fully drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.fetch_en) state_d = RUN;
            RUN:     if (!bus.fetch_en && !pending && (count == 2'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Expose the activity state for observation.
    always_comb begin
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch.
// The memory model returns 0xE000_0000 + address one cycle after each read strobe.
// Inputs change on the falling edge, and outputs are sampled 1 time unit later.
module tb_instr_fetch;

    localparam int AW = 7;
    localparam int IW = 32;

    logic clk;
    logic rst_n;
    logic dbg_state;
    int   n_cmp;
    int   n_err;

    instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    instr_fetch #(
        .ADDR_NUM   (128),
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .RESET_PC   (0)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memory model.
    always @(posedge clk) begin
        if (bus.imem_rd_en) begin
            bus.imem_rdata <= 32'hE000_0000 + 32'(bus.imem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to the next falling edge.
    task automatic cycle_chk(input string tag, input bit erd, input int eaddr,
                             input bit ev, input int epc);
        #1;
        check({tag, "_rd_en"}, 64'(bus.imem_rd_en), 64'(erd));
        if (erd) check({tag, "_addr"}, 64'(bus.imem_addr), 64'(eaddr));
        check({tag, "_valid"}, 64'(bus.instr_valid), 64'(ev));
        if (ev) begin
            check({tag, "_pc"}, 64'(bus.instr_pc), 64'(epc));
            check({tag, "_instr"}, 64'(bus.instr_out), 64'(32'hE000_0000 + epc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.imem_rdata     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_rd_en", 64'(bus.imem_rd_en), 64'd0);
        check("rst_instr", 64'(bus.instr_out), 64'd0);
        check("rst_pc", 64'(bus.instr_pc), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);

        // 1: streaming from reset, first valid at cycle 2, no bubbles.
        rst_n = 1'b1;
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 10; c++) cycle_chk("t1", 1'b1, c, c >= 2, c - 2);

        // 2: decode stalls 5 cycles; FIFO fills to 2 and issue stops.
        bus.instr_ready = 1'b0;
        for (int c = 10; c < 15; c++) cycle_chk("t2_stall", 1'b0, 0, 1'b1, 8);
        bus.instr_ready = 1'b1;
        cycle_chk("t2_res", 1'b1, 10, 1'b1, 8);
        cycle_chk("t2_res", 1'b1, 11, 1'b1, 9);
        cycle_chk("t2_res", 1'b1, 12, 1'b1, 10);
        cycle_chk("t2_res", 1'b1, 13, 1'b1, 11);

        // 5: reset mid-stream with two entries buffered.
        bus.instr_ready = 1'b0;
        cycle_chk("t5_fill", 1'b0, 0, 1'b1, 12);
        #1;
        check("t5_pre_valid", 64'(bus.instr_valid), 64'd1);
        check("t5_pre_pc", 64'(bus.instr_pc), 64'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(bus.instr_valid), 64'd0);
        check("t5_rd_en", 64'(bus.imem_rd_en), 64'd0);
        check("t5_pc", 64'(bus.instr_pc), 64'd0);
        check("t5_instr", 64'(bus.instr_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;

        // 3: restart at 0, then redirect to 40 while head=5 and 6 is in flight.
        for (int c = 0; c < 7; c++) cycle_chk("t3_pre", 1'b1, c, c >= 2, c - 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 7'd40;
        cycle_chk("t3_r", 1'b1, 40, 1'b1, 5);
        bus.redirect_valid = 1'b0;
        cycle_chk("t3_r1", 1'b1, 41, 1'b0, 0);
        cycle_chk("t3_post", 1'b1, 42, 1'b1, 40);
        cycle_chk("t3_post", 1'b1, 43, 1'b1, 41);
        cycle_chk("t3_post", 1'b1, 44, 1'b1, 42);

        // 6: fetch_en low for 3 cycles; the in-flight word still arrives.
        bus.fetch_en = 1'b0;
        cycle_chk("t6_off", 1'b0, 0, 1'b1, 43);
        cycle_chk("t6_off", 1'b0, 0, 1'b1, 44);
        cycle_chk("t6_off", 1'b0, 0, 1'b0, 0);
        bus.fetch_en = 1'b1;
        #1;
        check("t6_idle", 64'(dbg_state), 64'd0);
        cycle_chk("t6_on", 1'b1, 45, 1'b0, 0);
        #1;
        check("t6_run", 64'(dbg_state), 64'd1);
        cycle_chk("t6_on", 1'b1, 46, 1'b0, 0);
        cycle_chk("t6_on", 1'b1, 47, 1'b1, 45);
        cycle_chk("t6_on", 1'b1, 48, 1'b1, 46);

        // 4: redirect to the last word; pcs wrap 127 -> 0 -> 1.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 7'd127;
        cycle_chk("t4_r", 1'b1, 127, 1'b1, 47);
        bus.redirect_valid = 1'b0;
        cycle_chk("t4_r1", 1'b1, 0, 1'b0, 0);
        cycle_chk("t4_wrap", 1'b1, 1, 1'b1, 127);
        cycle_chk("t4_wrap", 1'b1, 2, 1'b1, 0);
        cycle_chk("t4_wrap", 1'b1, 3, 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
